cache_access_controller: RTL
============================

// Module: cache_access_controller
// PURPOSE
//  Sequences all accesses to the fully-associative cache and shares it between two requesters.
//  Arbitrates round-robin, probes the cache, and on a read miss fetches from main memory,
//  fills the cache and returns the data. Writes are write-through: cache and memory are both updated.
//  Sits between the requesters and the cache/main-memory pair; it is the only block driving the cache.
// PARAMETERS
//  ADDRESS_WIDTH  32  byte address width; matches `ADDRESS_WIDTH of the cache
//  DATA_WIDTH     32  data word width; matches `DATA_WIDTH of the cache
// PORTS
//  clk            in   1      clock; all logic on posedge
//  rst            in   1      synchronous reset, active-low (rst==0 resets)
//  req_valid      in   2      per-requester request valid; held until req_ready
//  req_ready      out  2      one-hot grant pulse; the request is accepted when req_valid&req_ready
//  req_wr         in   2      per-requester 1=write, 0=read
//  req_addr       in   2*AW   per-requester address; requester i at [i*AW +: AW]
//  req_wdata      in   2*DW   per-requester write data; requester i at [i*DW +: DW]
//  rsp_valid      out  2      one-hot 1-cycle response pulse to the granted requester; no backpressure
//  rsp_rdata      out  DW     read data; valid with rsp_valid (0 for writes)
//  rsp_hit        out  1      1 = served from cache; valid with rsp_valid
//  cache_wren     out  1      cache fill/write strobe, 1 cycle
//  cache_addr     out  AW     cache lookup/write address
//  cache_data     out  DW     cache write data
//  cache_hit      in   1      combinational hit for cache_addr
//  cache_rdata    in   DW     combinational data for cache_addr when cache_hit
//  mem_req_valid  out  1      main-memory request valid; held until mem_req_ready
//  mem_req_ready  in   1      main-memory accepts the request
//  mem_wr         out  1      1=write, 0=read; stable with mem_req_valid
//  mem_addr       out  AW     memory address; stable with mem_req_valid
//  mem_wdata      out  DW     memory write data; stable with mem_req_valid
//  mem_rsp_valid  in   1      read data return pulse (reads only)
//  mem_rsp_data   in   DW     read data, valid with mem_rsp_valid
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (requester 0 favoured). All outputs are 0, including the latched addr/data.
//  FSM: IDLE->LOOKUP->{RESP | MEM_REQ->MEM_WAIT->FILL->RESP | WR_MEM->RESP}->IDLE.
//  IDLE: req_ready is asserted only here, for the single winner.
//   - Winner: if both requests are valid, pick requester rr_ptr. If only one is valid, pick it.
//   - On accept: latch id/wr/addr/wdata, set rr_ptr=~id, go to LOOKUP. If no request is valid, stay.
//  LOOKUP: cache_addr = latched addr.
//   - Read hit: capture cache_rdata, go to RESP.
//   - Read miss: go to MEM_REQ.
//   - Write: cache_wren=1 with cache_data=wdata (cache allocates/overwrites), go to WR_MEM.
//  MEM_REQ: mem_req_valid=1, mem_wr=0. On mem_req_ready, go to MEM_WAIT.
//  MEM_WAIT: wait for mem_rsp_valid. Capture mem_rsp_data, then go to FILL.
//  FILL: cache_wren=1, cache_addr=addr, cache_data=captured data. Go to RESP.
//  WR_MEM: mem_req_valid=1, mem_wr=1, mem_wdata=wdata. On mem_req_ready, go to RESP.
//  RESP: rsp_valid[id]=1 for 1 cycle, then IDLE.
//   - rsp_hit=1 only for a read hit. rsp_rdata = read data, or 0 for writes.
//  Latency from accept cycle T: read hit rsp at T+2.
//   - Read miss rsp at T+4+(mem_req_ready wait)+(mem_rsp latency).
//   - Write rsp at T+3+(mem_req_ready wait).
//  One access is outstanding at a time. A new grant can occur no earlier than the cycle after RESP.
//  Unchanged while waiting: mem_* outputs are stable while mem_req_valid && !mem_req_ready.
//  Ignored input: mem_rsp_valid outside MEM_WAIT is ignored and dropped.
//  Not tracked: req_valid deasserting without a grant is legal and is not tracked.
//  Reset mid-operation: abort to IDLE next cycle.
//   - Drop any pending mem request; do not issue a response or a partial fill.
//   - rr_ptr returns to 0.
//  Cache-full replacement is owned by the cache; the controller does not track cache occupancy.
// TESTING
//  Reset, then read 0x10 (req0). Memory returns 0xAAAA after 3 cycles.
//   -> mem_addr=0x10, then a fill, then rsp_valid=01, rdata=0xAAAA, hit=0.
//  Reread 0x10 (req0) -> rsp_valid=01 at T+2, rdata=0xAAAA, hit=1, no mem_req_valid.
//  req0 and req1 both valid from reset, 3 back-to-back reads.
//   -> grants in order 01,10,01; responses in matching order.
//  Write 0x20=0x1234 (req1) with mem_req_ready low for 2 cycles.
//   -> cache_wren once; mem_wr=1 with addr/data stable; rsp_valid=10 after ready.
//   -> A following read of 0x20 gives hit=1, rdata=0x1234.
//  rst=0 asserted in MEM_WAIT.
//   -> IDLE next cycle; no rsp_valid, no cache_wren; a late mem_rsp_valid is ignored.
//  Stray mem_rsp_valid while IDLE -> no state change, no outputs toggle.

Source files
------------

// File: rtl/cache_access_controller.sv
// cache_access_controller
//
// Sequences all accesses to a fully-associative cache and shares it between two requesters.
// A round-robin arbiter picks one request at a time. The controller probes the cache, and on a
// read miss it fetches the word from main memory, fills the cache and returns the data. Writes
// are write-through: the cache is written during the lookup, then main memory is updated.
// Only one access is outstanding at a time.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   req_valid/ready/wr[1:0]     per-requester handshake and direction (1 = write)
//   req_addr, req_wdata         packed per-requester address / write data (requester i at i*W)
//   rsp_valid[1:0]              one-hot single-cycle response pulse to the granted requester
//   rsp_rdata, rsp_hit          read data (0 for writes) and cache-hit flag, valid with rsp_valid
//   cache_wren/addr/data        cache write strobe, lookup/write address, write data
//   cache_hit, cache_rdata      combinational cache lookup result for cache_addr
//   mem_req_valid/ready         main-memory request handshake
//   mem_wr/addr/wdata           main-memory request fields, stable while the request waits
//   mem_rsp_valid/data          main-memory read data return
module cache_access_controller #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_wr,
  input  logic [2*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0]    req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_hit,
  output logic                       cache_wren,
  output logic [ADDRESS_WIDTH-1:0]   cache_addr,
  output logic [DATA_WIDTH-1:0]      cache_data,
  input  logic                       cache_hit,
  input  logic [DATA_WIDTH-1:0]      cache_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_wr,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rsp_data
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemReq,
    StMemWait,
    StFill,
    StWrMem,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;  // requester favoured when both are valid
  logic          id_q, id_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;    // read data to return; stays 0 for writes
  logic          hit_q, hit_d;

  logic [1:0]    grant;
  logic          grant_id;

  // Round-robin winner: rr_ptr only matters when both requesters are valid.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
    grant_id = grant[1];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;

    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_rdata     = '0;
    rsp_hit       = 1'b0;
    cache_wren    = 1'b0;
    cache_addr    = addr_q;
    cache_data    = '0;
    mem_req_valid = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;

    unique case (state_q)
      StIdle: begin
        req_ready = grant;
        if (|grant) begin
          id_d     = grant_id;
          wr_d     = req_wr[grant_id];
          addr_d   = req_addr[grant_id*AW +: AW];
          wdata_d  = req_wdata[grant_id*DW +: DW];
          rdata_d  = '0;
          hit_d    = 1'b0;
          rr_ptr_d = ~grant_id;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        if (wr_q) begin
          // Write-through: the cache allocates or overwrites the line now.
          cache_wren = 1'b1;
          cache_data = wdata_q;
          state_d    = StWrMem;
        end else if (cache_hit) begin
          rdata_d = cache_rdata;
          hit_d   = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StMemReq;
        end
      end
      StMemReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_data;
          state_d = StFill;
        end
      end
      StFill: begin
        cache_wren = 1'b1;
        cache_data = rdata_q;
        state_d    = StResp;
      end
      StWrMem: begin
        mem_req_valid = 1'b1;
        mem_wr        = 1'b1;
        if (mem_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid = id_q ? 2'b10 : 2'b01;
        rsp_rdata = rdata_q;
        rsp_hit   = hit_q;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // While reset is asserted no handshake or strobe may escape: a pending memory request is
    // dropped and no response or partial fill is issued.
    if (!rst) begin
      req_ready     = 2'b00;
      rsp_valid     = 2'b00;
      cache_wren    = 1'b0;
      mem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
    end
  end

endmodule
